// File: rtl/peripheral_gpio_apb4_if.sv
// APB4 slave bus bundle for the GPIO peripheral; the master modport drives requests, the slave modport answers.
interface peripheral_gpio_apb4_if #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8
);
  logic                    PSEL;
  logic                    PENABLE;
  logic [PADDR_SIZE-1:0]   PADDR;
  logic                    PWRITE;
  logic [PDATA_SIZE/8-1:0] PSTRB;
  logic [PDATA_SIZE-1:0]   PWDATA;
  logic [PDATA_SIZE-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/peripheral_gpio_apb4.sv
// APB4 GPIO slave: register file, pad drivers, 2-flop input sync, per-pin triggers, level IRQ.
// Optional macro GPIO_PSLVERR_EN: flag unmapped accesses and writes to INPUT with PSLVERR.
module peripheral_gpio_apb4 #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  peripheral_gpio_apb4_if.slave apb,
  input  logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] gpio_oe,
  output logic                  irq_o
);
  localparam logic [3:0] A_MODE = 4'h0, A_DIR = 4'h1, A_OUT = 4'h2, A_IN = 4'h3;
  localparam logic [3:0] A_TTYP = 4'h4, A_TPOL = 4'h5, A_TSTA = 4'h6, A_IENA = 4'h7;

  logic [PDATA_SIZE-1:0] mode_q, dir_q, out_q, tr_type_q, tr_pol_q, irq_ena_q;
  logic [PDATA_SIZE-1:0] tr_status_q, tr_status_d;
  logic [PDATA_SIZE-1:0] in_s1_q, in_s2_q, in_d_q;
  logic [PDATA_SIZE-1:0] prdata_q, prdata_d;
  logic [PDATA_SIZE-1:0] wmask, w1c, trig, edge_hit, level_hit;
  logic                  irq_q;
  logic [3:0]            addr;
  logic                  wr_en, rd_setup;
  logic                  unused_paddr;

  // Handshake: setup phase is PSEL&~PENABLE, access phase is PSEL&PENABLE; PREADY is
  // constantly 1 so every transfer completes at the end of its first access cycle.
  assign addr         = apb.PADDR[3:0];
  assign wr_en        = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_setup     = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  assign unused_paddr = ^apb.PADDR[PADDR_SIZE-1:4];

  always_comb begin
    wmask = '0;
    for (int i = 0; i < PDATA_SIZE/8; i++) wmask[i*8 +: 8] = {8{apb.PSTRB[i]}};
  end

  // Trigger detection runs on synchronised samples only; in_d lags in_s2 by one cycle.
  assign level_hit = ~(in_s2_q ^ tr_pol_q);
  assign edge_hit  = (tr_pol_q & in_s2_q & ~in_d_q) | (~tr_pol_q & ~in_s2_q & in_d_q);
  assign trig      = (tr_type_q & edge_hit) | (~tr_type_q & level_hit);

  // A new trigger in the same cycle as a W1C keeps the bit set.
  assign w1c         = (wr_en && addr == A_TSTA) ? (apb.PWDATA & wmask) : '0;
  assign tr_status_d = (tr_status_q & ~w1c) | trig;

  always_comb begin
    prdata_d = prdata_q;
    if (rd_setup) begin
      case (addr)
        A_MODE:  prdata_d = mode_q;
        A_DIR:   prdata_d = dir_q;
        A_OUT:   prdata_d = out_q;
        A_IN:    prdata_d = in_s2_q;
        A_TTYP:  prdata_d = tr_type_q;
        A_TPOL:  prdata_d = tr_pol_q;
        A_TSTA:  prdata_d = tr_status_q;
        A_IENA:  prdata_d = irq_ena_q;
        default: prdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mode_q      <= '0;
      dir_q       <= '0;
      out_q       <= '0;
      tr_type_q   <= '0;
      tr_pol_q    <= '0;
      irq_ena_q   <= '0;
      tr_status_q <= '0;
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      in_d_q      <= '0;
      prdata_q    <= '0;
      irq_q       <= 1'b0;
    end else begin
      in_s1_q     <= gpio_i;
      in_s2_q     <= in_s1_q;
      in_d_q      <= in_s2_q;
      tr_status_q <= tr_status_d;
      irq_q       <= |(tr_status_q & irq_ena_q);
      prdata_q    <= prdata_d;
      if (wr_en) begin
        case (addr)
          A_MODE: mode_q    <= (mode_q    & ~wmask) | (apb.PWDATA & wmask);
          A_DIR:  dir_q     <= (dir_q     & ~wmask) | (apb.PWDATA & wmask);
          A_OUT:  out_q     <= (out_q     & ~wmask) | (apb.PWDATA & wmask);
          A_TTYP: tr_type_q <= (tr_type_q & ~wmask) | (apb.PWDATA & wmask);
          A_TPOL: tr_pol_q  <= (tr_pol_q  & ~wmask) | (apb.PWDATA & wmask);
          A_IENA: irq_ena_q <= (irq_ena_q & ~wmask) | (apb.PWDATA & wmask);
          default: ;
        endcase
      end
    end
  end

  // Open-drain pins never drive high: they release (oe=0) for a 1 and pull low for a 0.
  assign gpio_o  = out_q & ~mode_q;
  assign gpio_oe = dir_q & ~(mode_q & out_q);
  assign irq_o   = irq_q;

  assign apb.PRDATA = prdata_q;
  assign apb.PREADY = 1'b1;
`ifdef GPIO_PSLVERR_EN
  logic bad_access;
  assign bad_access  = addr[3] | (apb.PWRITE & (addr == A_IN));
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & bad_access;
`else
  assign apb.PSLVERR = 1'b0;
`endif
endmodule
